psg_filter_seq: RTL

PSG_FILTER_SEQ -- requirements
Module: psg_filter_seq

---
 rtl/psg_pkg.sv | 21 ++
 rtl/psg_slot_counter.sv | 46 ++++
 rtl/psg_filter_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared constants and types for the PSG filter sequencer.
package psg_pkg;

  // Default filter geometry: one MAC slot per tap, clocks per output sample.
  localparam int TAPS_DEF   = 16;
  localparam int PERIOD_DEF = 256;

  // Datapath widths.
  localparam int CNT_W  = 8;
  localparam int ADR_W  = 4;
  localparam int COEF_W = 13;

  // Coefficient write path: IDLE accepts a host request, PEND waits for the
  // MAC window to close, WRITE is the single cycle in which wr is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    WRITE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/psg_slot_counter.sv
// MAC slot counter. Counts 0..PERIOD-1 while enabled. When disabled it still
// finishes an open MAC window (cnt < TAPS) and then freezes at TAPS.
module psg_slot_counter
  import psg_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             advance;

  // Next count: advance when enabled or when a MAC window is still open.
  always_comb begin
    advance = en_i || (cnt_q < TAPS_C);
    cnt_d   = cnt_q;
    if (advance) begin
      cnt_d = (cnt_q == LAST) ? '0 : (cnt_q + ONE);
    end
  end

  // Counter register; reset parks on the last slot so the first counted
  // cycle after reset is slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/psg_filter_seq.sv
// PSG filter sequencer: slot counter plus a host coefficient write path that
// only writes the filter outside its MAC window.
//
// Host handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_adr/cfg_dat are sampled on that edge only.
// cfg_ready does not depend on cfg_valid, and the host must hold its request
// stable until it transfers.
module psg_filter_seq
  import psg_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADR_W-1:0]  cfg_adr,
  input  logic [COEF_W-1:0] cfg_dat,
  output logic [CNT_W-1:0]  cnt,
  output logic              wr,
  output logic [ADR_W-1:0]  adr,
  output logic [COEF_W-1:0] din,
  output logic              sample_stb,
  output logic              mac_busy,
  output wr_state_t         dbg_state
);

  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

  logic [CNT_W-1:0]  cnt_next;
  logic              safe_next;
  logic              accept;

  wr_state_t         state_q, state_d;
  logic [ADR_W-1:0]  hold_adr_q, hold_adr_d;
  logic [COEF_W-1:0] hold_dat_q, hold_dat_d;
  logic              wr_q, wr_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [COEF_W-1:0] din_q, din_d;

  psg_slot_counter #(
    .TAPS   (TAPS),
    .PERIOD (PERIOD)
  ) u_slot_counter (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next)
  );

  // The cycle after the coming edge lies outside the MAC window.
  assign safe_next  = (cnt_next >= TAPS_C);
  assign sample_stb = (cnt == '0);
  assign mac_busy   = (cnt < TAPS_C);

  // Only IDLE accepts; reset forces ready low combinationally.
  assign cfg_ready = (state_q == IDLE) && !rst;
  assign accept    = cfg_valid && cfg_ready;

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_adr_q <= '0;
      hold_dat_q <= '0;
      wr_q       <= 1'b0;
      adr_q      <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_adr_q <= hold_adr_d;
      hold_dat_q <= hold_dat_d;
      wr_q       <= wr_d;
      adr_q      <= adr_d;
      din_q      <= din_d;
    end
  end

  // Next state: go straight to WRITE when the next cycle is already safe,
  // otherwise wait in PEND until it is.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = safe_next ? WRITE : PEND;
        end
      end
      PEND: begin
        if (safe_next) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold-register capture and registered strobe/address/data for the filter.
  always_comb begin
    hold_adr_d = hold_adr_q;
    hold_dat_d = hold_dat_q;
    wr_d       = 1'b0;
    adr_d      = adr_q;
    din_d      = din_q;
    if (accept) begin
      hold_adr_d = cfg_adr;
      hold_dat_d = cfg_dat;
    end
    if (state_d == WRITE) begin
      wr_d = 1'b1;
      if (state_q == IDLE) begin
        adr_d = cfg_adr;
        din_d = cfg_dat;
      end else begin
        adr_d = hold_adr_q;
        din_d = hold_dat_q;
      end
    end
  end

  assign wr        = wr_q;
  assign adr       = adr_q;
  assign din       = din_q;
  assign dbg_state = state_q;

endmodule
